// File: rtl/fcn_pkg.sv
// Shared types for the FCN datapath: operand word, default width and feeder FSM states.
package fcn_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef logic signed [DW_DEFAULT-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain with async active-high clear; DEPTH=0 collapses to a wire.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] i_d,
  output logic signed [DW-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic signed [DW-1:0] r_pipe [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed operand lanes into the systolic array: clear pulse, streaming with
// zero bubbles on stalls, SIZE-1 cycle flush, then a one-cycle done.
module systolic_feeder
  import fcn_pkg::*;
#(
  parameter int unsigned SIZE = 2,
  parameter int unsigned DW   = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_act,
  input  logic signed [DW-1:0] in_net [SIZE],
  input  logic                 in_last,
  output logic                 arr_clr,
  output logic signed [DW-1:0] input_weight,
  output logic signed [DW-1:0] net_weight [SIZE],
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW         = (SIZE > 2) ? $clog2(SIZE - 1) : 1;
  localparam int unsigned FLUSH_LAST = (SIZE > 1) ? (SIZE - 2) : 0;

  feeder_state_t        r_state;
  feeder_state_t        w_state_nxt;
  logic [CW-1:0]        r_flush_cnt;
  logic [CW-1:0]        w_flush_cnt_nxt;
  logic                 w_accept;
  logic                 w_in_ready_nxt;
  logic                 w_arr_clr_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 r_in_ready;
  logic                 r_arr_clr;
  logic                 r_busy;
  logic                 r_done;
  logic signed [DW-1:0] r_act;
  logic signed [DW-1:0] r_stage0 [SIZE];

  assign w_accept = (r_state == STREAM) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = '0;
    case (r_state)
      IDLE:   if (start) w_state_nxt = CLEAR;
      CLEAR:  w_state_nxt = STREAM;
      STREAM: begin
        if (w_accept && in_last) w_state_nxt = (SIZE == 1) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (r_flush_cnt == CW'(FLUSH_LAST)) w_state_nxt = DONE;
        else                                 w_flush_cnt_nxt = r_flush_cnt + CW'(1);
      end
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with r_state.
  always_comb begin
    w_in_ready_nxt = (w_state_nxt == STREAM);
    w_arr_clr_nxt  = (w_state_nxt == CLEAR);
    w_busy_nxt     = (w_state_nxt != IDLE);
    w_done_nxt     = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_arr_clr  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_arr_clr  <= w_arr_clr_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Stage 0 takes the accepted vector, otherwise a zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act <= '0;
      for (int i = 0; i < SIZE; i++) r_stage0[i] <= '0;
    end else begin
      r_act <= w_accept ? in_act : '0;
      for (int i = 0; i < SIZE; i++) r_stage0[i] <= w_accept ? in_net[i] : '0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < SIZE; g++) begin : g_lane
      skew_delay_line #(
        .DEPTH(g),
        .DW   (DW)
      ) u_skew (
        .clk(clk),
        .rst(rst),
        .i_d(r_stage0[g]),
        .o_q(net_weight[g])
      );
    end
  endgenerate

  assign in_ready     = r_in_ready;
  assign arr_clr      = r_arr_clr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign input_weight = r_act;

endmodule
